// File: rtl/spi_slave_axi_ctrl_if.sv
// AXI4-Lite style single-beat bus bundle used between the SPI slave controller
// (master side) and the system interconnect or memory (slave side).
interface spi_slave_axi_ctrl_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
);

    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_valid;
    logic                        w_ready;

    logic [1:0]                  b_resp;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_valid;
    logic                        r_ready;

    modport master (
        output aw_addr, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input b_resp, b_valid, output b_ready,
        output ar_addr, ar_valid, input ar_ready,
        input r_data, r_resp, r_valid, output r_ready
    );

    modport slave (
        input aw_addr, aw_valid, output aw_ready,
        input w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input ar_addr, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );

endinterface

// File: rtl/spi_slave_axi_ctrl.sv
// SPI slave bus controller: turns synchronized SPI frame requests into
// single-beat AXI4-Lite style reads and writes, streaming words between the
// RX/TX FIFOs and the bus with address auto-increment while the frame is open.
module spi_slave_axi_ctrl #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                      sys_clk,
    input  logic                      rstn,
    input  logic                      cs_sync,
    input  logic [AXI_ADDR_WIDTH-1:0] address_sync,
    input  logic                      address_valid_sync,
    input  logic                      rd_wr_sync,
    input  logic [AXI_DATA_WIDTH-1:0] rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic [AXI_DATA_WIDTH-1:0] tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    spi_slave_axi_ctrl_if.master      axi,
    output logic                      bus_err
);

    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        RD_PUSH,
        WR_WAIT,
        WR_AW_W,
        WR_B
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_DATA_WIDTH-1:0] r_txData;
    logic [AXI_DATA_WIDTH-1:0] r_wrData;
    logic                      r_awDone;
    logic                      r_wDone;
    logic                      r_busErr;

    logic                      w_awHs;
    logic                      w_wHs;
    logic                      w_awFin;
    logic                      w_wFin;

    // A channel counts as finished once its handshake happened earlier or happens now.
    assign w_awHs  = (r_state == WR_AW_W) && !r_awDone && axi.aw_ready;
    assign w_wHs   = (r_state == WR_AW_W) && !r_wDone && axi.w_ready;
    assign w_awFin = r_awDone || w_awHs;
    assign w_wFin  = r_wDone || w_wHs;

    assign tx_data     = r_txData;
    assign axi.ar_addr = r_addr;
    assign axi.aw_addr = r_addr;
    assign axi.w_data  = r_wrData;
    assign axi.w_strb  = '1;
    assign bus_err     = r_busErr;

    // State register; reset drops any transaction in flight.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs, all derived from the current state.
    always_comb begin
        w_nextState  = r_state;
        rx_ready     = 1'b0;
        tx_valid     = 1'b0;
        axi.ar_valid = 1'b0;
        axi.r_ready  = 1'b0;
        axi.aw_valid = 1'b0;
        axi.w_valid  = 1'b0;
        axi.b_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (address_valid_sync) begin
                    w_nextState = rd_wr_sync ? RD_AR : WR_WAIT;
                end
            end
            RD_AR: begin
                axi.ar_valid = 1'b1;
                if (axi.ar_ready) begin
                    w_nextState = RD_R;
                end
            end
            RD_R: begin
                axi.r_ready = 1'b1;
                if (axi.r_valid) begin
                    w_nextState = RD_PUSH;
                end
            end
            RD_PUSH: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    w_nextState = cs_sync ? IDLE : RD_AR;
                end
            end
            WR_WAIT: begin
                rx_ready = rx_valid;
                if (rx_valid) begin
                    w_nextState = WR_AW_W;
                end else if (cs_sync) begin
                    w_nextState = IDLE;
                end
            end
            WR_AW_W: begin
                axi.aw_valid = !r_awDone;
                axi.w_valid  = !r_wDone;
                if (w_awFin && w_wFin) begin
                    w_nextState = WR_B;
                end
            end
            WR_B: begin
                axi.b_ready = 1'b1;
                if (axi.b_valid) begin
                    w_nextState = WR_WAIT;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Address, data capture, per-channel completion flags and the error pulse.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_addr   <= '0;
            r_txData <= '0;
            r_wrData <= '0;
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
            r_busErr <= 1'b0;
        end else begin
            r_busErr <= ((r_state == RD_R) && axi.r_valid && (axi.r_resp != 2'b00)) ||
                        ((r_state == WR_B) && axi.b_valid && (axi.b_resp != 2'b00));
            case (r_state)
                IDLE: begin
                    if (address_valid_sync) begin
                        r_addr <= address_sync;
                    end
                end
                RD_R: begin
                    if (axi.r_valid) begin
                        r_txData <= axi.r_data;
                    end
                end
                RD_PUSH: begin
                    if (tx_ready && !cs_sync) begin
                        r_addr <= r_addr + ADDR_STEP;
                    end
                end
                WR_WAIT: begin
                    if (rx_valid) begin
                        r_wrData <= rx_data;
                        r_awDone <= 1'b0;
                        r_wDone  <= 1'b0;
                    end
                end
                WR_AW_W: begin
                    if (w_awHs) begin
                        r_awDone <= 1'b1;
                    end
                    if (w_wHs) begin
                        r_wDone <= 1'b1;
                    end
                end
                WR_B: begin
                    if (axi.b_valid) begin
                        r_addr <= r_addr + ADDR_STEP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_axi_ctrl.sv
// Self-checking bench for spi_slave_axi_ctrl: an RX FIFO model, a bus slave
// model with adjustable ready/response timing, and scoreboards of expected
// AR addresses, bus writes and TX pushes checked as the DUT produces them.
module tb_spi_slave_axi_ctrl;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wrExp_t;

    logic        sys_clk;
    logic        rstn;
    logic        cs_sync;
    logic [31:0] address_sync;
    logic        address_valid_sync;
    logic        rd_wr_sync;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_err;

    spi_slave_axi_ctrl_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) axiIf ();

    spi_slave_axi_ctrl #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
        .sys_clk            (sys_clk),
        .rstn               (rstn),
        .cs_sync            (cs_sync),
        .address_sync       (address_sync),
        .address_valid_sync (address_valid_sync),
        .rd_wr_sync         (rd_wr_sync),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .rx_ready           (rx_ready),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .axi                (axiIf),
        .bus_err            (bus_err)
    );

    wrExp_t      expWrQ[$];
    logic [31:0] expArQ[$];
    logic [31:0] expTxQ[$];
    logic [31:0] rxQ[$];
    logic [31:0] rdDataQ[$];
    logic [1:0]  bRespQ[$];

    int compareCount = 0;
    int mismatchCount = 0;

    int awDelay = 0;
    int wDelay = 0;
    int rDelay = 0;

    int awCnt, wCnt, rCnt, rPending;
    bit awSeen, wSeen, bPending, bDone, rDone;
    logic [31:0] gotAwAddr, gotWData;
    logic [3:0]  gotStrb;

    int arCount, txCount, awHsCount, wHsCount, bHsCount, busErrCount, awOnlyCount;

    // Free-running system clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: time limit reached before the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] handshakeVector();
        return {axiIf.ar_valid, axiIf.r_ready, axiIf.aw_valid, axiIf.w_valid,
                axiIf.b_ready, rx_ready, tx_valid, bus_err};
    endfunction

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic rdWr);
        @(posedge sys_clk);
        #1;
        cs_sync            = 1'b0;
        address_sync       = addr;
        rd_wr_sync         = rdWr;
        address_valid_sync = 1'b1;
        @(posedge sys_clk);
        #1;
        address_valid_sync = 1'b0;
    endtask

    task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
        wrExp_t e;
        e.addr = addr;
        e.data = data;
        rxQ.push_back(data);
        expWrQ.push_back(e);
    endtask

    task automatic expectRead(input logic [31:0] addr, input logic [31:0] data);
        expArQ.push_back(addr);
        rdDataQ.push_back(data);
        expTxQ.push_back(data);
    endtask

    task automatic waitQuiet(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge sys_clk);
            #1;
            if (expWrQ.size() == 0 && expArQ.size() == 0 && expTxQ.size() == 0 &&
                rxQ.size() == 0 && !bPending && rPending == 0 &&
                !axiIf.b_valid && !axiIf.r_valid && handshakeVector() == 8'h00) begin
                done = 1'b1;
            end
        end
        checkOutput(tag, done, 1'b1);
    endtask

    // RX FIFO model, bus slave model and scoreboard monitor: observe at negedge, drive after posedge.
    initial begin
        wrExp_t e;
        axiIf.aw_ready = 1'b0;
        axiIf.w_ready  = 1'b0;
        axiIf.b_valid  = 1'b0;
        axiIf.b_resp   = 2'b00;
        axiIf.ar_ready = 1'b0;
        axiIf.r_valid  = 1'b0;
        axiIf.r_data   = '0;
        axiIf.r_resp   = 2'b00;
        rx_valid = 1'b0;
        rx_data  = '0;
        awCnt = 0; wCnt = 0; rCnt = 0; rPending = 0;
        awSeen = 0; wSeen = 0; bPending = 0; bDone = 0; rDone = 0;
        forever begin
            @(negedge sys_clk);
            if (rstn) begin
                if (rx_valid && rx_ready && rxQ.size() != 0) begin
                    void'(rxQ.pop_front());
                end
                if (axiIf.aw_valid && axiIf.aw_ready) begin
                    awSeen = 1'b1;
                    gotAwAddr = axiIf.aw_addr;
                    awHsCount++;
                end
                if (axiIf.w_valid && axiIf.w_ready) begin
                    wSeen = 1'b1;
                    gotWData = axiIf.w_data;
                    gotStrb = axiIf.w_strb;
                    wHsCount++;
                end
                if (awSeen && wSeen) begin
                    awSeen = 1'b0;
                    wSeen = 1'b0;
                    bPending = 1'b1;
                    checkOutput("writeExpected", expWrQ.size() != 0, 1'b1);
                    if (expWrQ.size() != 0) begin
                        e = expWrQ.pop_front();
                        checkOutput("awAddr", gotAwAddr, e.addr);
                        checkOutput("wData", gotWData, e.data);
                        checkOutput("wStrb", gotStrb, 4'hF);
                    end
                end
                if (axiIf.b_valid && axiIf.b_ready) begin
                    bDone = 1'b1;
                    bHsCount++;
                end
                if (axiIf.ar_valid && axiIf.ar_ready) begin
                    arCount++;
                    rPending++;
                    checkOutput("arExpected", expArQ.size() != 0, 1'b1);
                    if (expArQ.size() != 0) begin
                        checkOutput("arAddr", axiIf.ar_addr, expArQ.pop_front());
                    end
                end
                if (axiIf.r_valid && axiIf.r_ready) begin
                    rDone = 1'b1;
                end
                if (tx_valid && tx_ready) begin
                    txCount++;
                    checkOutput("txExpected", expTxQ.size() != 0, 1'b1);
                    if (expTxQ.size() != 0) begin
                        checkOutput("txData", tx_data, expTxQ.pop_front());
                    end
                end
                if (bus_err) begin
                    busErrCount++;
                end
                if (axiIf.aw_valid && !axiIf.w_valid) begin
                    awOnlyCount++;
                end
            end
            @(posedge sys_clk);
            #1;
            if (!rstn) begin
                axiIf.aw_ready = 1'b0;
                axiIf.w_ready  = 1'b0;
                axiIf.b_valid  = 1'b0;
                axiIf.b_resp   = 2'b00;
                axiIf.ar_ready = 1'b0;
                axiIf.r_valid  = 1'b0;
                awCnt = 0; wCnt = 0; rCnt = 0; rPending = 0;
                awSeen = 0; wSeen = 0; bPending = 0; bDone = 0; rDone = 0;
            end else begin
                if (axiIf.aw_valid) begin
                    axiIf.aw_ready = (awCnt >= awDelay);
                    awCnt++;
                end else begin
                    axiIf.aw_ready = 1'b0;
                    awCnt = 0;
                end
                if (axiIf.w_valid) begin
                    axiIf.w_ready = (wCnt >= wDelay);
                    wCnt++;
                end else begin
                    axiIf.w_ready = 1'b0;
                    wCnt = 0;
                end
                axiIf.ar_ready = axiIf.ar_valid;
                if (bDone) begin
                    axiIf.b_valid = 1'b0;
                    axiIf.b_resp  = 2'b00;
                    bDone = 1'b0;
                end else if (bPending && !axiIf.b_valid) begin
                    axiIf.b_valid = 1'b1;
                    axiIf.b_resp  = (bRespQ.size() != 0) ? bRespQ.pop_front() : 2'b00;
                    bPending = 1'b0;
                end
                if (rDone) begin
                    axiIf.r_valid = 1'b0;
                    rDone = 1'b0;
                end
                if (!axiIf.r_valid && rPending > 0) begin
                    if (rCnt >= rDelay) begin
                        axiIf.r_valid = 1'b1;
                        axiIf.r_data  = (rdDataQ.size() != 0) ? rdDataQ.pop_front() : 32'h0;
                        axiIf.r_resp  = 2'b00;
                        rPending--;
                        rCnt = 0;
                    end else begin
                        rCnt++;
                    end
                end
            end
            rx_valid = (rxQ.size() != 0);
            rx_data  = rx_valid ? rxQ[0] : 32'h0;
        end
    end

    // Test sequence.
    initial begin
        bit seen;
        rstn               = 1'b0;
        cs_sync            = 1'b1;
        address_sync       = '0;
        address_valid_sync = 1'b0;
        rd_wr_sync         = 1'b0;
        tx_ready           = 1'b1;
        arCount = 0; txCount = 0; awHsCount = 0; wHsCount = 0; bHsCount = 0;
        busErrCount = 0; awOnlyCount = 0;

        stepCycles(3);
        checkOutput("resetHandshakes", handshakeVector(), 8'h00);
        checkOutput("resetArAddr", axiIf.ar_addr, 32'h0);
        checkOutput("resetWData", axiIf.w_data, 32'h0);
        checkOutput("resetTxData", tx_data, 32'h0);
        rstn = 1'b1;
        stepCycles(2);

        $display("[TB] write frame at 0x1000");
        expectWrite(32'h0000_1000, 32'hDEAD_BEEF);
        expectWrite(32'h0000_1004, 32'h1234_5678);
        applyStimulus(32'h0000_1000, 1'b0);
        waitQuiet("writeFrameDone", 80);
        cs_sync = 1'b1;
        stepCycles(2);
        rxQ.push_back(32'h5555_5555);
        stepCycles(3);
        checkOutput("writeEndsIdleRxValid", rx_valid, 1'b1);
        checkOutput("writeEndsIdleNoPop", rx_ready, 1'b0);
        rxQ.delete();
        stepCycles(2);

        $display("[TB] read frame at 0x2000, chip select rises during second R");
        rDelay = 2;
        arCount = 0;
        txCount = 0;
        expectRead(32'h0000_2000, 32'hA5A5_A5A5);
        expectRead(32'h0000_2004, 32'h5A5A_5A5A);
        applyStimulus(32'h0000_2000, 1'b1);
        checkOutput("arLatency", axiIf.ar_valid, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (arCount >= 2) seen = 1'b1;
            else stepCycles(1);
        end
        checkOutput("secondArIssued", seen, 1'b1);
        checkOutput("csRiseDuringR", axiIf.r_ready, 1'b1);
        cs_sync = 1'b1;
        waitQuiet("readFrameDone", 60);
        stepCycles(5);
        checkOutput("readArCount", arCount, 2);
        checkOutput("readTxCount", txCount, 2);
        rDelay = 0;

        $display("[TB] TX backpressure");
        arCount = 0;
        tx_ready = 1'b0;
        expectRead(32'h0000_3000, 32'h0BAD_F00D);
        applyStimulus(32'h0000_3000, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (tx_valid) seen = 1'b1;
            else stepCycles(1);
        end
        checkOutput("txValidRaised", seen, 1'b1);
        for (int i = 0; i < 5; i++) begin
            stepCycles(1);
            checkOutput("txHoldValid", tx_valid, 1'b1);
            checkOutput("txHoldData", tx_data, 32'h0BAD_F00D);
            checkOutput("noArDuringHold", axiIf.ar_valid, 1'b0);
        end
        cs_sync = 1'b1;
        tx_ready = 1'b1;
        waitQuiet("backpressureDone", 40);
        checkOutput("backpressureArCount", arCount, 1);

        $display("[TB] write channel skew");
        awDelay = 3;
        awHsCount = 0;
        wHsCount = 0;
        bHsCount = 0;
        awOnlyCount = 0;
        expectWrite(32'h0000_4000, 32'hCAFE_F00D);
        applyStimulus(32'h0000_4000, 1'b0);
        waitQuiet("skewWriteDone", 60);
        cs_sync = 1'b1;
        stepCycles(2);
        checkOutput("skewAwOnlyCycles", awOnlyCount, 3);
        checkOutput("skewWHandshakes", wHsCount, 1);
        checkOutput("skewAwHandshakes", awHsCount, 1);
        checkOutput("skewBHandshakes", bHsCount, 1);
        awDelay = 0;

        $display("[TB] error response");
        busErrCount = 0;
        bRespQ.push_back(2'b10);
        expectWrite(32'h0000_5000, 32'h1111_1111);
        expectWrite(32'h0000_5004, 32'h2222_2222);
        applyStimulus(32'h0000_5000, 1'b0);
        waitQuiet("errorFrameDone", 80);
        cs_sync = 1'b1;
        stepCycles(2);
        checkOutput("busErrPulseCycles", busErrCount, 1);

        $display("[TB] reset during RD_R");
        rDelay = 20;
        expectRead(32'h0000_6000, 32'h7777_7777);
        applyStimulus(32'h0000_6000, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (axiIf.r_ready) seen = 1'b1;
            else stepCycles(1);
        end
        checkOutput("reachedReadData", seen, 1'b1);
        rstn = 1'b0;
        #1;
        checkOutput("midResetHandshakes", handshakeVector(), 8'h00);
        checkOutput("midResetArAddr", axiIf.ar_addr, 32'h0);
        checkOutput("midResetTxData", tx_data, 32'h0);
        expArQ.delete();
        expTxQ.delete();
        rdDataQ.delete();
        rDelay = 0;
        cs_sync = 1'b1;
        stepCycles(3);
        rstn = 1'b1;
        stepCycles(3);
        checkOutput("postResetIdle", handshakeVector(), 8'h00);

        $display("[TB] address wrap with chip select raised alongside pending RX words");
        expectWrite(32'hFFFF_FFFC, 32'hAAAA_0001);
        expectWrite(32'h0000_0000, 32'hAAAA_0002);
        applyStimulus(32'hFFFF_FFFC, 1'b0);
        cs_sync = 1'b1;
        waitQuiet("wrapDone", 80);
        stepCycles(2);
        checkOutput("finalIdle", handshakeVector(), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/spi_slave_axi_ctrl.md
Name: spi_slave_axi_ctrl

Overview:
- Sits in the sys_clk domain, directly downstream of the SPI-to-system synchronizer.
- Consumes the synchronized chip-select, start address, address-valid pulse and read/write flag.
- Converts them into single-beat AXI4-Lite-style bus transactions: pops write words from the RX FIFO and pushes read words into the TX FIFO.
- Auto-increments the address while the SPI frame stays active, so one frame can stream many words.

Parameters:
AXI_ADDR_WIDTH, 32, width of the bus address and of address_sync
AXI_DATA_WIDTH, 32, bus data width; address increment is AXI_DATA_WIDTH/8

Ports:
sys_clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
cs_sync  in  1  synchronized chip select, active-low (1 = frame ended)
address_sync  in  AXI_ADDR_WIDTH  start address, stable while address_valid_sync is high
address_valid_sync  in  1  one-cycle pulse: new address available
rd_wr_sync  in  1  1 = read frame, 0 = write frame; sampled with address_valid_sync
rx_data  in  AXI_DATA_WIDTH  write word from RX FIFO
rx_valid  in  1  RX FIFO not empty
rx_ready  out  1  pop RX FIFO
tx_data  out  AXI_DATA_WIDTH  read word to TX FIFO
tx_valid  out  1  push request to TX FIFO
tx_ready  in  1  TX FIFO not full
aw_addr / aw_valid / aw_ready  out/out/in  AXI_ADDR_WIDTH/1/1  write address channel
w_data / w_strb / w_valid / w_ready  out/out/out/in  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1  write data channel
b_resp / b_valid / b_ready  in/in/out  2/1/1  write response channel
ar_addr / ar_valid / ar_ready  out/out/in  AXI_ADDR_WIDTH/1/1  read address channel
r_data / r_resp / r_valid / r_ready  in/in/in/out  AXI_DATA_WIDTH/2/1/1  read data channel
bus_err  out  1  one-cycle pulse on any non-OKAY response

Behaviour:
- Reset values (asynchronous, immediate): all valid/ready outputs 0, bus_err 0, address register 0, data registers 0, state IDLE.
- Reset mid-transaction drops every handshake; no completion is owed.
- FSM states: IDLE, RD_AR, RD_R, RD_PUSH, WR_WAIT, WR_AW_W, WR_B.
- IDLE:
  - address_valid_sync=1 → latch address_sync.
  - rd_wr_sync=1 → RD_AR; rd_wr_sync=0 → WR_WAIT.
  - address_valid_sync is ignored in every other state.
- RD_AR: ar_valid=1, ar_addr=latched address. On ar_ready → RD_R.
  - Latency: pulse at cycle N gives ar_valid at N+1.
- RD_R: r_ready=1. On r_valid, capture r_data into tx_data; bus_err pulses if r_resp≠0; → RD_PUSH.
- RD_PUSH: tx_valid=1 until tx_ready. On the handshake:
  - cs_sync=0 → address += AXI_DATA_WIDTH/8, → RD_AR (prefetch of the next word).
  - cs_sync=1 → IDLE.
- WR_WAIT: rx_ready = rx_valid (combinational pop). On a pop, latch rx_data → WR_AW_W.
  - Else if cs_sync=1 → IDLE.
  - rx_valid and cs_sync=1 in the same cycle: the pop wins and the word is written.
- WR_AW_W:
  - aw_valid and w_valid are asserted together; w_strb is all ones.
  - Each valid deasserts independently after its own handshake.
  - Once both handshakes are done (same or different cycles) → WR_B.
- WR_B: b_ready=1. On b_valid: bus_err pulses if b_resp≠0; address += AXI_DATA_WIDTH/8; → WR_WAIT.
- An error response never aborts the frame; read data is still pushed.
- Address increment wraps modulo 2^AXI_ADDR_WIDTH.
- cs_sync rising during a bus transaction: the transaction completes, then → IDLE. No new transaction is issued after cs_sync=1.
- AXI valids are never withdrawn before their handshake.

Test Plan:
- Write frame: addr 0x1000, rd_wr=0, RX words 0xDEADBEEF, 0x12345678, then cs_sync=1 → AW at 0x1000/0x1004 with those data, w_strb=0xF, then IDLE.
- Read frame: addr 0x2000, rd_wr=1, memory returns 0xA5A5A5A5, 0x5A5A5A5A, cs_sync rises during the second R → exactly 2 TX pushes in order, no third AR, IDLE.
- Write channel skew: aw_ready delayed 3 cycles after w_ready → w_valid drops after its handshake, aw_valid holds, single B wait, one bus write.
- TX backpressure: tx_ready=0 for 5 cycles in RD_PUSH → tx_valid and tx_data held stable, no new AR until the push completes.
- Error response: b_resp=2'b10 → bus_err high exactly 1 cycle, next word is still written at address+4.
- Wrap and reset: start address 0xFFFFFFFC, 2-word write → second AW at 0x00000000. rstn low during RD_R → all valids/readies 0 immediately, state IDLE.
